// File: rtl/tick_divider_chain_if.sv
// Control and status bundle for tick_divider_chain. The timebase owner drives
// it through the master modport, and the divider drives it through the slave modport.
interface tick_divider_chain_if #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3
);
    // Load is a single-cycle request that is sampled on the rising edge of Clock.
    // Divisor only needs to be valid in that cycle. It has no ready signal:
    // a rejected request is reported one cycle later on LoadErr.
    logic              Enable;
    logic              Clear;
    logic              Load;
    logic [WIDTH-1:0]  Divisor;
    logic [STAGES:0]   Tick;
    logic [STAGES:0]   Square;
    logic [WIDTH-1:0]  CurDivisor;
    logic              LoadErr;

    modport master (
        output Enable, Clear, Load, Divisor,
        input  Tick, Square, CurDivisor, LoadErr
    );

    modport slave (
        input  Enable, Clear, Load, Divisor,
        output Tick, Square, CurDivisor, LoadErr
    );
endinterface

// File: rtl/tick_divider_chain.sv
// Timebase generator: a loadable base divider followed by fixed-ratio prescalers.
// Define TICK_DIVIDER_CHAIN_RUNTIME_LOAD_EN to enable runtime loading of the base divisor.
module tick_divider_chain #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 25000,
    parameter int STAGES      = 3,
    parameter int RATIO       = 10
) (
    input  logic                 Clock,
    input  logic                 Reset,
    tick_divider_chain_if.slave  bus
);
    localparam int              CW      = $clog2(RATIO);
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [CW-1:0]    LAST_K  = CW'(RATIO - 1);
    localparam logic [CW-1:0]    ONE_K   = CW'(1);

    logic [WIDTH-1:0] r_c0;
    logic [CW-1:0]    r_ck [STAGES];
    logic [STAGES:0]  r_tick;
    logic [STAGES:0]  r_square;
    logic             r_load_err;

    logic [WIDTH-1:0] w_cur_div;
    logic [WIDTH-1:0] w_last_c0;
    logic [STAGES:0]  w_term;
    logic             w_load_ok;
    logic             w_load_bad;

`ifdef TICK_DIVIDER_CHAIN_RUNTIME_LOAD_EN
    logic [WIDTH-1:0] r_cur_div;

    assign w_load_ok  = bus.Load && (bus.Divisor > ONE);
    assign w_load_bad = bus.Load && (bus.Divisor <= ONE);
    assign w_cur_div  = r_cur_div;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_cur_div <= DEF_DIV;
        end else if (!bus.Clear && w_load_ok) begin
            r_cur_div <= bus.Divisor;
        end
    end
`else
    logic w_unused_load;

    assign w_load_ok     = 1'b0;
    assign w_load_bad    = 1'b0;
    assign w_cur_div     = DEF_DIV;
    assign w_unused_load = &{1'b0, bus.Load, bus.Divisor};
`endif

    // Terminal flags ripple combinationally, so stages that finish together tick in the same cycle.
    // The >= comparison keeps a counter from running past its terminal value.
    always_comb begin
        logic v_term;
        w_last_c0 = w_cur_div - ONE;
        w_term    = '0;
        v_term    = bus.Enable && (r_c0 >= w_last_c0);
        w_term[0] = v_term;
        for (int k = 1; k <= STAGES; k++) begin
            v_term    = v_term && (r_ck[k-1] >= LAST_K);
            w_term[k] = v_term;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_c0       <= '0;
            r_tick     <= '0;
            r_square   <= '0;
            r_load_err <= 1'b0;
            for (int k = 0; k < STAGES; k++) r_ck[k] <= '0;
        end else if (bus.Clear) begin
            r_c0       <= '0;
            r_tick     <= '0;
            r_square   <= '0;
            r_load_err <= 1'b0;
            for (int k = 0; k < STAGES; k++) r_ck[k] <= '0;
        end else if (w_load_ok) begin
            r_c0       <= '0;
            r_tick     <= '0;
            r_load_err <= 1'b0;
            for (int k = 0; k < STAGES; k++) r_ck[k] <= '0;
        end else begin
            // When Enable is low every w_term bit is 0, so Tick clears and Square holds.
            r_load_err <= w_load_bad;
            r_tick     <= w_term;
            r_square   <= r_square ^ w_term;
            if (bus.Enable) begin
                r_c0 <= w_term[0] ? '0 : r_c0 + ONE;
                for (int k = 1; k <= STAGES; k++) begin
                    if (w_term[k]) begin
                        r_ck[k-1] <= '0;
                    end else if (w_term[k-1]) begin
                        r_ck[k-1] <= r_ck[k-1] + ONE_K;
                    end
                end
            end
        end
    end

    assign bus.Tick       = r_tick;
    assign bus.Square     = r_square;
    assign bus.CurDivisor = w_cur_div;
    assign bus.LoadErr    = r_load_err;
endmodule

// File: tb/tb_tick_divider_chain.sv
// Self-checking bench for tick_divider_chain, using a period-arithmetic reference and a scoreboard queue.
// Load behaviour follows TICK_DIVIDER_CHAIN_RUNTIME_LOAD_EN.
module tb_tick_divider_chain;
    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 5;
    localparam int STAGES      = 2;
    localparam int RATIO       = 3;
    localparam int EW          = 1 + WIDTH + 2 * (STAGES + 1);
`ifdef TICK_DIVIDER_CHAIN_RUNTIME_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    tick_divider_chain_if #(.WIDTH(WIDTH), .STAGES(STAGES)) bus ();

    tick_divider_chain #(
        .WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV), .STAGES(STAGES), .RATIO(RATIO)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    // The reference counts enabled cycles since the last restart. Tick k fires whenever
    // that count is a multiple of the stage period, and Square is the parity of completed periods.
    int              m_cnt;
    int              m_div;
    logic [STAGES:0] m_sq_base;
    logic [STAGES:0] m_tick;
    logic            m_lerr;

    function automatic logic [STAGES:0] model_square();
        logic [STAGES:0] sq;
        for (int k = 0; k <= STAGES; k++) begin
            sq[k] = m_sq_base[k] ^ (((m_cnt / (m_div * RATIO ** k)) % 2) == 1);
        end
        return sq;
    endfunction

    function automatic logic [EW-1:0] observed();
        return {bus.LoadErr, bus.CurDivisor, bus.Square, bus.Tick};
    endfunction

    function automatic logic [EW-1:0] reset_word();
        return {1'b0, WIDTH'(DEFAULT_DIV), {(2 * (STAGES + 1)){1'b0}}};
    endfunction

    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt     = 0;
        m_div     = DEFAULT_DIV;
        m_sq_base = '0;
        m_tick    = '0;
        m_lerr    = 1'b0;
    endtask

    // One clock: update the reference from the inputs sampled at the edge, queue the expectation,
    // then compare it against the DUT shortly after the edge.
    task automatic step(input string tag);
        logic [STAGES:0] cur_sq;
        @(posedge Clock);
        cur_sq = model_square();
        m_lerr = 1'b0;
        m_tick = '0;
        if (bus.Clear) begin
            m_cnt     = 0;
            m_sq_base = '0;
        end else if (LOAD_EN && bus.Load && bus.Divisor >= 2) begin
            m_sq_base = cur_sq;
            m_div     = int'(bus.Divisor);
            m_cnt     = 0;
        end else begin
            m_lerr = LOAD_EN && bus.Load && (bus.Divisor < 2);
            if (bus.Enable) begin
                m_cnt++;
                for (int k = 0; k <= STAGES; k++) begin
                    if (m_cnt % (m_div * RATIO ** k) == 0) m_tick[k] = 1'b1;
                end
            end
        end
        exp_q.push_back({m_lerr, WIDTH'(m_div), model_square(), m_tick});
        #1;
        check(tag, observed(), exp_q.pop_front());
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        Reset       = 1'b1;
        bus.Enable  = 1'b0;
        bus.Clear   = 1'b0;
        bus.Load    = 1'b0;
        bus.Divisor = '0;
        model_reset();
        #12;
        exp_q.push_back(reset_word());
        check("reset_values", observed(), exp_q.pop_front());

        // Free-running timebase. The first rising edge after release is edge 1.
        Reset      = 1'b0;
        bus.Enable = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            step("base_run");
            if (i == 15 || i == 30) check("stage1_tick", EW'(bus.Tick), EW'(3'b011));
            if (i == 45) check("coincident_tick", EW'(bus.Tick), EW'(3'b111));
        end
        run(3, "to_c0_3");

        // Four-cycle enable gap while the base counter holds 3.
        bus.Enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step("enable_gap");
            check("gap_tick_low", EW'(bus.Tick), EW'(0));
        end
        bus.Enable = 1'b1;
        run(12, "after_gap");

        // Accepted load in the middle of a count, then a rejected one.
        bus.Divisor = 8'd7;
        bus.Load    = 1'b1;
        step("load7");
        bus.Load = 1'b0;
        run(22, "period7");
        bus.Divisor = 8'd1;
        bus.Load    = 1'b1;
        step("load1_reject");
        bus.Load = 1'b0;
        run(16, "after_reject");

        // Clear has priority over a simultaneous load.
        bus.Clear   = 1'b1;
        bus.Load    = 1'b1;
        bus.Divisor = 8'd9;
        step("clear_load");
        bus.Clear = 1'b0;
        bus.Load  = 1'b0;
        run(12, "after_clear");

        // Mixed random enable, clear and load traffic.
        for (int i = 0; i < 60; i++) begin
            bus.Enable  = ($urandom_range(0, 3) != 0);
            bus.Clear   = ($urandom_range(0, 19) == 0);
            bus.Load    = ($urandom_range(0, 14) == 0);
            bus.Divisor = WIDTH'($urandom_range(0, 9));
            step("random_mix");
        end
        bus.Enable = 1'b1;
        bus.Clear  = 1'b0;
        bus.Load   = 1'b0;
        run(5, "settle");

        // Asynchronous reset between edges.
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        model_reset();
        exp_q.push_back(reset_word());
        check("async_reset", observed(), exp_q.pop_front());
        @(negedge Clock);
        Reset = 1'b0;
        run(30, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
